// File: rtl/sdp_chk_pkg.sv
// rtl/sdp_chk_pkg.sv - shared latency, FSM encoding and golden-model function for the response checker.
package sdp_chk_pkg;

  localparam int LAT    = 3;
  localparam int MAX_W  = 32;
  localparam int WCNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_CHECK  = 2'd2,
    ST_HALT   = 2'd3
  } chk_state_e;

  // Low W bits of the result depend only on the low W bits of the operands.
  function automatic logic [MAX_W-1:0] calc_exp(
    input logic             sel_add_ab,
    input logic             sel_add_c,
    input logic [MAX_W-1:0] op_a,
    input logic [MAX_W-1:0] op_b,
    input logic [MAX_W-1:0] op_c
  );
    logic [MAX_W-1:0] m;
    m = sel_add_ab ? (op_a + op_b) : (op_a - op_b);
    return sel_add_c ? (m + op_c) : (m - op_c);
  endfunction

endpackage

// File: rtl/sdp_exp_pipe.sv
// rtl/sdp_exp_pipe.sv - expected-value delay line; each slot carries a value and an armed bit.
module sdp_exp_pipe #(
  parameter int W     = 1,
  parameter int DEPTH = 3
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] push_val_i,
  input  logic         push_arm_i,
  input  logic         reload_i,
  output logic [W-1:0] tail_val_o,
  output logic         tail_arm_o
);

  logic [W-1:0]     val_q [DEPTH];
  logic [W-1:0]     val_d [DEPTH];
  logic [DEPTH-1:0] arm_q;
  logic [DEPTH-1:0] arm_d;

  always_comb begin
    val_d = val_q;
    arm_d = arm_q;
    if (reload_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        val_d[i] = '0;
        arm_d[i] = 1'b1;
      end
    end else begin
      val_d[0] = push_val_i;
      arm_d[0] = push_arm_i;
      for (int i = 1; i < DEPTH; i++) begin
        val_d[i] = val_q[i-1];
        arm_d[i] = arm_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        val_q[i] <= '0;
      end
      arm_q <= '0;
    end else begin
      val_q <= val_d;
      arm_q <= arm_d;
    end
  end

  assign tail_val_o = val_q[DEPTH-1];
  assign tail_arm_o = arm_q[DEPTH-1];

endmodule

// File: rtl/sdp_rsp_checker.sv
// rtl/sdp_rsp_checker.sv - scores a datapath's result LAT cycles after its operands against a golden model.
module sdp_rsp_checker
  import sdp_chk_pkg::*;
#(
  parameter int W     = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             dut_reset,
  input  logic             ctl_1,
  input  logic             ctl_2,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [W-1:0]     c,
  input  logic [W-1:0]     dut_out,
  input  logic             chk_en,
  input  logic             stop_on_err,
  output logic             err,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] checked_cnt,
  output logic [W-1:0]     first_exp,
  output logic [W-1:0]     first_act,
  output logic [1:0]       state
);

  chk_state_e        state_q, state_d;
  logic [WCNT_W-1:0] warm_q, warm_d;
  logic [CNT_W-1:0]  checked_q, checked_d, mis_q, mis_d;
  logic              err_q, err_d;
  logic [W-1:0]      fexp_q, fexp_d, fact_q, fact_d;

  logic [W-1:0] push_val, tail_val;
  logic         push_arm, tail_arm, score, mismatch;

  assign push_val = W'(calc_exp(ctl_1, ctl_2, MAX_W'(a), MAX_W'(b), MAX_W'(c)));
  assign push_arm = (state_q == ST_WARMUP) || (state_q == ST_CHECK);

  sdp_exp_pipe #(.W(W), .DEPTH(LAT)) u_pipe (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .push_val_i (push_val),
    .push_arm_i (push_arm),
    .reload_i   (dut_reset),
    .tail_val_o (tail_val),
    .tail_arm_o (tail_arm)
  );

  // The tail is scored before a simultaneous dut_reset reloads the line.
  assign score    = tail_arm && chk_en && (state_q == ST_CHECK);
  assign mismatch = score && (tail_val != dut_out);

  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_WARMUP;
        warm_d  = '0;
      end
      ST_WARMUP: begin
        if (dut_reset || (warm_q == WCNT_W'(LAT - 1))) begin
          state_d = ST_CHECK;
          warm_d  = '0;
        end else begin
          warm_d = warm_q + 1'b1;
        end
      end
      ST_CHECK: begin
        if (mismatch && stop_on_err) state_d = ST_HALT;
      end
      ST_HALT: state_d = ST_HALT;
    endcase
  end

  always_comb begin
    checked_d = checked_q;
    mis_d     = mis_q;
    err_d     = err_q;
    fexp_d    = fexp_q;
    fact_d    = fact_q;
    if (score) begin
      if (checked_q != '1) checked_d = checked_q + 1'b1;
      if (mismatch) begin
        if (mis_q != '1) mis_d = mis_q + 1'b1;
        if (!err_q) begin
          err_d  = 1'b1;
          fexp_d = tail_val;
          fact_d = dut_out;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      warm_q    <= '0;
      checked_q <= '0;
      mis_q     <= '0;
      err_q     <= 1'b0;
      fexp_q    <= '0;
      fact_q    <= '0;
    end else begin
      state_q   <= state_d;
      warm_q    <= warm_d;
      checked_q <= checked_d;
      mis_q     <= mis_d;
      err_q     <= err_d;
      fexp_q    <= fexp_d;
      fact_q    <= fact_d;
    end
  end

  assign err          = err_q;
  assign mismatch_cnt = mis_q;
  assign checked_cnt  = checked_q;
  assign first_exp    = fexp_q;
  assign first_act    = fact_q;
  assign state        = state_q;

endmodule

// File: tb/tb_sdp_rsp_checker.sv
// tb/tb_sdp_rsp_checker.sv - self-checking bench for sdp_rsp_checker (W=4, plus a CNT_W=2 saturation instance).
module tb_sdp_rsp_checker;

  localparam int W     = 4;
  localparam int CNT_W = 8;
  localparam logic [1:0] S_IDLE = 2'd0, S_WARM = 2'd1, S_CHECK = 2'd2, S_HALT = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, dut_reset, ctl_1, ctl_2, chk_en, stop_on_err;
  logic [W-1:0] a, b, c, dut_out;

  logic             err;
  logic [CNT_W-1:0] mismatch_cnt, checked_cnt;
  logic [W-1:0]     first_exp, first_act;
  logic [1:0]       state;

  logic         s_err;
  logic [1:0]   s_mis, s_chk;
  logic [W-1:0] s_fexp, s_fact;
  logic [1:0]   s_state;

  sdp_rsp_checker #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .dut_reset(dut_reset), .ctl_1(ctl_1), .ctl_2(ctl_2),
    .a(a), .b(b), .c(c), .dut_out(dut_out), .chk_en(chk_en), .stop_on_err(stop_on_err),
    .err(err), .mismatch_cnt(mismatch_cnt), .checked_cnt(checked_cnt),
    .first_exp(first_exp), .first_act(first_act), .state(state)
  );

  sdp_rsp_checker #(.W(W), .CNT_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .dut_reset(dut_reset), .ctl_1(ctl_1), .ctl_2(ctl_2),
    .a(a), .b(b), .c(c), .dut_out(dut_out), .chk_en(chk_en), .stop_on_err(stop_on_err),
    .err(s_err), .mismatch_cnt(s_mis), .checked_cnt(s_chk),
    .first_exp(s_fexp), .first_act(s_fact), .state(s_state)
  );

  typedef struct {
    logic       c1;
    logic       c2;
    logic [3:0] va;
    logic [3:0] vb;
    logic [3:0] vc;
    logic [3:0] exp;
    logic [3:0] act;
  } vec_t;

  typedef struct {
    logic [3:0] exp;
    logic [3:0] act;
  } sb_t;

  vec_t vecs[11];
  sb_t  sb_q[$];

  int checks = 0;
  int errors = 0;

  int         e_chk, e_mis;
  logic       e_err;
  logic [3:0] e_fexp, e_fact;
  logic [1:0] e_st;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("state", int'(state), int'(e_st));
    chk("checked_cnt", int'(checked_cnt), e_chk);
    chk("mismatch_cnt", int'(mismatch_cnt), e_mis);
    chk("err", int'(err), int'(e_err));
    chk("first_exp", int'(first_exp), int'(e_fexp));
    chk("first_act", int'(first_act), int'(e_fact));
    chk("sat_checked_cnt", int'(s_chk), (e_chk > 3) ? 3 : e_chk);
  endtask

  task automatic clear_exp();
    e_chk = 0; e_mis = 0; e_err = 1'b0; e_fexp = '0; e_fact = '0; e_st = S_IDLE;
  endtask

  task automatic score(input logic [3:0] ex, input logic [3:0] ac);
    e_chk++;
    if (ex != ac) begin
      e_mis++;
      if (!e_err) begin
        e_err = 1'b1; e_fexp = ex; e_fact = ac;
      end
    end
  endtask

  // Drives one cycle's inputs at a falling edge and returns at the next falling edge.
  task automatic cyc(input logic c1, input logic c2, input logic [3:0] ia, input logic [3:0] ib,
                     input logic [3:0] ic, input logic [3:0] dout, input logic drst);
    ctl_1 = c1; ctl_2 = c2; a = ia; b = ib; c = ic; dut_out = dout; dut_reset = drst;
    @(negedge clk);
  endtask

  task automatic warmup(input logic [3:0] dout);
    cyc(1, 1, 0, 0, 0, dout, 0); e_st = S_WARM;  check_all();
    cyc(1, 1, 0, 0, 0, dout, 0); e_st = S_WARM;  check_all();
    cyc(1, 1, 0, 0, 0, dout, 0); e_st = S_WARM;  check_all();
    cyc(1, 1, 0, 0, 0, dout, 0); e_st = S_CHECK; check_all();
  endtask

  initial begin
    vecs[0]  = '{1, 0,  5,  3,  2,  6,  6};
    vecs[1]  = '{1, 1,  7,  8,  3,  2,  2};
    vecs[2]  = '{0, 0,  2,  5,  4,  9,  9};
    vecs[3]  = '{0, 1,  1,  3,  1, 15,  0};
    vecs[4]  = '{1, 1, 15, 15, 15, 13,  2};
    vecs[5]  = '{0, 0,  0,  0,  0,  0,  0};
    vecs[6]  = '{1, 0,  9,  4, 10,  3,  3};
    vecs[7]  = '{0, 1,  8,  9,  9,  8,  8};
    vecs[8]  = '{1, 1,  0,  0,  0,  0,  0};
    vecs[9]  = '{1, 1,  0,  0,  0,  0,  0};
    vecs[10] = '{1, 1,  0,  0,  0,  0,  0};

    reset_n = 1'b0; dut_reset = 1'b0; ctl_1 = 1'b0; ctl_2 = 1'b0;
    a = '0; b = '0; c = '0; dut_out = '0; chk_en = 1'b1; stop_on_err = 1'b0;
    clear_exp();
    repeat (2) @(negedge clk);
    check_all();
    reset_n = 1'b1;

    // Streaming vectors: operands driven now, their result fed back three edges later.
    cyc(1, 1, 0, 0, 0, 0, 0); e_st = S_WARM; check_all();
    for (int i = 0; i < 11; i++) begin
      sb_t ent;
      logic scored;
      scored = 1'b0;
      dut_out = '0;
      if (sb_q.size() == 3) begin
        ent = sb_q.pop_front();
        scored = 1'b1;
      end
      sb_q.push_back('{vecs[i].exp, vecs[i].act});
      cyc(vecs[i].c1, vecs[i].c2, vecs[i].va, vecs[i].vb, vecs[i].vc,
          scored ? ent.act : 4'd0, 1'b0);
      if (scored) score(ent.exp, ent.act);
      e_st = (i + 2 >= 4) ? S_CHECK : S_WARM;
      check_all();
    end
    sb_q.delete();

    // Asynchronous reset mid-CHECK, then warm-up with garbage results that must not be scored.
    #2 reset_n = 1'b0;
    #1 clear_exp(); check_all();
    @(negedge clk);
    reset_n = 1'b1;
    warmup(4'hA);
    cyc(1, 1, 0, 0, 0, 0, 0); score(0, 0); check_all();
    chk_en = 1'b0;
    cyc(1, 1, 0, 0, 0, 9, 0); check_all();
    chk_en = 1'b1;
    cyc(1, 1, 0, 0, 0, 0, 0); score(0, 0); check_all();

    // dut_reset with a coincident mismatch: tail scored first, then the line reloads as zeros.
    cyc(vecs[1].c1, vecs[1].c2, vecs[1].va, vecs[1].vb, vecs[1].vc, 5, 1); score(0, 5); check_all();
    cyc(vecs[0].c1, vecs[0].c2, vecs[0].va, vecs[0].vb, vecs[0].vc, 0, 0); score(0, 0); check_all();
    cyc(1, 1, 0, 0, 0, 0, 0); score(0, 0); check_all();
    cyc(1, 1, 0, 0, 0, 0, 0); score(0, 0); check_all();
    cyc(1, 1, 0, 0, 0, 6, 0); score(6, 6); check_all();

    // stop_on_err: first mismatch halts; later mismatches and dut_reset change nothing.
    reset_n = 1'b0;
    @(negedge clk);
    clear_exp(); check_all();
    reset_n = 1'b1;
    stop_on_err = 1'b1;
    warmup(4'h0);
    cyc(1, 1, 0, 0, 0, 3, 0); score(0, 3); e_st = S_HALT; check_all();
    cyc(1, 1, 0, 0, 0, 7, 0); check_all();
    cyc(1, 1, 0, 0, 0, 0, 1); check_all();
    cyc(1, 1, 0, 0, 0, 5, 0); check_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
